// File: rtl/ifu_bpu_if.sv
// EXU branch-response channel: vld/rdy handshake carrying the resolved branch packet.
// RV_PC_SIZE defaults to 32 unless the build defines it.
`ifndef RV_PC_SIZE
`define RV_PC_SIZE 32
`endif

interface ex_rsp_if_t;
  typedef struct packed {
    logic [`RV_PC_SIZE-1:0] pc;
    logic                   taken;
    logic [`RV_PC_SIZE-1:0] target_pc;
    logic                   pred_true;
  } pkt_t;

  logic vld;
  logic rdy;
  pkt_t pkt;

  modport slv (input vld, input pkt, output rdy);
  modport mst (output vld, output pkt, input rdy);
endinterface

// File: rtl/ifu_bpu.sv
// Direct-mapped BTB with 2-bit counters, combinational fetch lookup and a registered
// one-entry redirect buffer. Define IFU_BPU_STATS_EN to add stat_br/stat_mis counters.
`ifndef RV_PC_SIZE
`define RV_PC_SIZE 32
`endif

module ifu_bpu #(
  parameter int BTB_ENTRIES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [`RV_PC_SIZE-1:0] fetch_pc,
  output logic                   pred_taken,
  output logic [`RV_PC_SIZE-1:0] pred_pc,
  ex_rsp_if_t.slv                ex_rsp_slv,
  output logic                   redirect_vld,
  output logic [`RV_PC_SIZE-1:0] redirect_pc,
  input  logic                   redirect_rdy
`ifdef IFU_BPU_STATS_EN
  ,
  output logic [31:0]            stat_br,
  output logic [31:0]            stat_mis
`endif
);

  localparam int PC_W  = `RV_PC_SIZE;
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_W - 2 - IDX_W;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  logic [BTB_ENTRIES-1:0] r_valid;
  logic [1:0]             r_cnt [BTB_ENTRIES];
  logic [TAG_W-1:0]       r_tag [BTB_ENTRIES];
  logic [PC_W-1:0]        r_tgt [BTB_ENTRIES];

  logic                   r_redir_vld_p1;
  logic [PC_W-1:0]        r_redir_pc_p1;

  logic [IDX_W-1:0]       w_f_idx;
  logic [TAG_W-1:0]       w_f_tag;
  logic                   w_f_hit;
  logic [IDX_W-1:0]       w_u_idx;
  logic [TAG_W-1:0]       w_u_tag;
  logic                   w_u_hit;
  logic                   w_acc;
  logic                   w_unused;

  // Fetch lookup: purely combinational, sees pre-update contents.
  assign w_f_idx    = fetch_pc[IDX_W+1:2];
  assign w_f_tag    = fetch_pc[PC_W-1:IDX_W+2];
  assign w_f_hit    = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
  assign pred_taken = w_f_hit && r_cnt[w_f_idx][1];
  assign pred_pc    = pred_taken ? r_tgt[w_f_idx] : fetch_pc + PC_W'(4);

  assign ex_rsp_slv.rdy = !r_redir_vld_p1;
  assign w_acc          = ex_rsp_slv.vld && !r_redir_vld_p1;

  assign w_u_idx = ex_rsp_slv.pkt.pc[IDX_W+1:2];
  assign w_u_tag = ex_rsp_slv.pkt.pc[PC_W-1:IDX_W+2];
  assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

  assign w_unused = ^{fetch_pc[1:0], ex_rsp_slv.pkt.pc[1:0]};

  // Training / control state: valid bits, counters and the redirect buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid        <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) r_cnt[i] <= 2'b00;
      r_redir_vld_p1 <= 1'b0;
      r_redir_pc_p1  <= '0;
    end else begin
      if (w_acc) begin
        if (ex_rsp_slv.pkt.taken) begin
          if (w_u_hit) begin
            r_cnt[w_u_idx] <= sat_inc(r_cnt[w_u_idx]);
          end else begin
            r_valid[w_u_idx] <= 1'b1;
            r_cnt[w_u_idx]   <= 2'b10;
          end
        end else if (w_u_hit) begin
          r_cnt[w_u_idx] <= sat_dec(r_cnt[w_u_idx]);
        end
      end
      if (w_acc && !ex_rsp_slv.pkt.pred_true) begin
        r_redir_vld_p1 <= 1'b1;
        r_redir_pc_p1  <= ex_rsp_slv.pkt.target_pc;
      end else if (r_redir_vld_p1 && redirect_rdy) begin
        r_redir_vld_p1 <= 1'b0;
      end
    end
  end

  // Tag/target payload is only meaningful behind a valid bit, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_acc && ex_rsp_slv.pkt.taken) begin
      r_tag[w_u_idx] <= w_u_tag;
      r_tgt[w_u_idx] <= ex_rsp_slv.pkt.target_pc;
    end
  end

  assign redirect_vld = r_redir_vld_p1;
  assign redirect_pc  = r_redir_pc_p1;

`ifdef IFU_BPU_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_br  <= '0;
      r_stat_mis <= '0;
    end else if (w_acc) begin
      r_stat_br <= sat_inc32(r_stat_br);
      if (!ex_rsp_slv.pkt.pred_true) r_stat_mis <= sat_inc32(r_stat_mis);
    end
  end

  assign stat_br  = r_stat_br;
  assign stat_mis = r_stat_mis;
`endif

endmodule

// File: tb/tb_ifu_bpu.sv
// Directed bench for ifu_bpu: reset, allocation, counter saturation, aliasing,
// redirect backpressure, async reset mid-redirect and (optionally) statistics.
`timescale 1ns/1ps

module tb_ifu_bpu;
  logic        clk;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        redirect_rdy;
`ifdef IFU_BPU_STATS_EN
  logic [31:0] stat_br;
  logic [31:0] stat_mis;
`endif

  int n_chk;
  int n_pass;

  ex_rsp_if_t rsp ();

  ifu_bpu #(.BTB_ENTRIES(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_pc     (fetch_pc),
    .pred_taken   (pred_taken),
    .pred_pc      (pred_pc),
    .ex_rsp_slv   (rsp),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .redirect_rdy (redirect_rdy)
`ifdef IFU_BPU_STATS_EN
    ,
    .stat_br      (stat_br),
    .stat_mis     (stat_mis)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present one response and hold it until accepted (bounded wait).
  task automatic send(input logic [31:0] pc, input logic taken,
                      input logic [31:0] tgt, input logic ptrue);
    int cyc;
    rsp.vld           = 1'b1;
    rsp.pkt.pc        = pc;
    rsp.pkt.taken     = taken;
    rsp.pkt.target_pc = tgt;
    rsp.pkt.pred_true = ptrue;
    cyc = 0;
    while (!rsp.rdy && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!rsp.rdy) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    rsp.vld = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_t, input logic [31:0] exp_pc);
    fetch_pc = pc;
    #1;
    chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_t});
    chk({tag, "_pc"}, pred_pc, exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    fetch_pc = 32'h100;
    redirect_rdy = 1'b1;
    rsp.vld = 1'b0;
    rsp.pkt = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;

    // T1 reset
    chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_pred_pc", pred_pc, 32'h104);
    chk("rst_redir_vld", {31'd0, redirect_vld}, 32'd0);
    chk("rst_redir_pc", redirect_pc, 32'd0);
    chk("rst_rdy", {31'd0, rsp.rdy}, 32'd1);

    // T2 allocate on mispredicted taken
    send(32'h100, 1'b1, 32'h40, 1'b0);
    chk("t2_redir_vld", {31'd0, redirect_vld}, 32'd1);
    chk("t2_redir_pc", redirect_pc, 32'h40);
    chk("t2_rdy_low", {31'd0, rsp.rdy}, 32'd0);
    look("t2_lookup", 32'h100, 1'b1, 32'h40);
    @(posedge clk); #1;
    chk("t2_redir_clr", {31'd0, redirect_vld}, 32'd0);

    // T3 saturation up then down
    repeat (3) send(32'h100, 1'b1, 32'h40, 1'b1);
    look("t3_sat11", 32'h100, 1'b1, 32'h40);
    send(32'h100, 1'b0, 32'h104, 1'b1);
    look("t3_nt1", 32'h100, 1'b1, 32'h40);
    send(32'h100, 1'b0, 32'h104, 1'b1);
    look("t3_nt2", 32'h100, 1'b0, 32'h104);
    send(32'h100, 1'b0, 32'h104, 1'b1);
    send(32'h100, 1'b0, 32'h104, 1'b1);
    look("t3_sat00", 32'h100, 1'b0, 32'h104);
    send(32'h100, 1'b1, 32'h48, 1'b1);
    look("t3_still_valid", 32'h100, 1'b0, 32'h104);
    send(32'h100, 1'b1, 32'h48, 1'b1);
    look("t3_retrain", 32'h100, 1'b1, 32'h48);
    send(32'h200, 1'b0, 32'h204, 1'b1);
    look("t3_nt_noalloc", 32'h200, 1'b0, 32'h204);
    look("t3_entry_kept", 32'h100, 1'b1, 32'h48);

    // T4 alias overwrite at the same index
    send(32'h140, 1'b1, 32'h80, 1'b0);
    chk("t4_redir_pc", redirect_pc, 32'h80);
    look("t4_new", 32'h140, 1'b1, 32'h80);
    look("t4_old_miss", 32'h100, 1'b0, 32'h104);

    // Same-cycle lookup and update: lookup sees the old counter
    @(posedge clk); #1;
    fetch_pc = 32'h140;
    rsp.vld = 1'b1;
    rsp.pkt.pc = 32'h140;
    rsp.pkt.taken = 1'b0;
    rsp.pkt.target_pc = 32'h144;
    rsp.pkt.pred_true = 1'b1;
    #1;
    chk("byp_pre_taken", {31'd0, pred_taken}, 32'd1);
    @(posedge clk); #1;
    rsp.vld = 1'b0;
    look("byp_post", 32'h140, 1'b0, 32'h144);

    // T5 redirect backpressure
    redirect_rdy = 1'b0;
    send(32'h300, 1'b1, 32'h90, 1'b0);
    rsp.vld = 1'b1;
    rsp.pkt.pc = 32'h384;
    rsp.pkt.taken = 1'b1;
    rsp.pkt.target_pc = 32'hA0;
    rsp.pkt.pred_true = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_held_vld", {31'd0, redirect_vld}, 32'd1);
    chk("t5_held_pc", redirect_pc, 32'h90);
    chk("t5_rdy_low", {31'd0, rsp.rdy}, 32'd0);
    look("t5_not_consumed", 32'h384, 1'b0, 32'h388);
    redirect_rdy = 1'b1;
    @(posedge clk); #1;
    chk("t5_clr_vld", {31'd0, redirect_vld}, 32'd0);
    chk("t5_pc_kept", redirect_pc, 32'h90);
    look("t5_still_miss", 32'h384, 1'b0, 32'h388);
    @(posedge clk); #1;
    rsp.vld = 1'b0;
    look("t5_consumed", 32'h384, 1'b1, 32'hA0);
    chk("t5_no_redir", {31'd0, redirect_vld}, 32'd0);

    // Async reset while a redirect is pending
    redirect_rdy = 1'b0;
    send(32'h500, 1'b1, 32'hC0, 1'b0);
    chk("t7_pending", {31'd0, redirect_vld}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_vld", {31'd0, redirect_vld}, 32'd0);
    chk("t7_rst_pc", redirect_pc, 32'd0);
    look("t7_rst_btb", 32'h384, 1'b0, 32'h388);
    @(posedge clk); #1;
    rst_n = 1'b1;
    redirect_rdy = 1'b1;

`ifdef IFU_BPU_STATS_EN
    // T6 statistics
    chk("t6_rst_br", stat_br, 32'd0);
    chk("t6_rst_mis", stat_mis, 32'd0);
    send(32'h600, 1'b1, 32'h10, 1'b1);
    send(32'h604, 1'b1, 32'h14, 1'b0);
    send(32'h608, 1'b0, 32'h60C, 1'b1);
    send(32'h60C, 1'b1, 32'h1C, 1'b0);
    send(32'h610, 1'b0, 32'h614, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_br", stat_br, 32'd5);
    chk("t6_mis", stat_mis, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
